// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among NUM_REQ byte streams using packet-locked
// round-robin arbitration, with an optional forced idle gap after every packet.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CND_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [15:0] GAP_LOAD = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [IDX_W-1:0]   gidx_r, gidx_nxt_s;
  logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_nxt_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic               win_found_s;
  logic [NUM_REQ-1:0] grant_r, grant_nxt_s;
  logic [15:0]        gap_cnt_r, gap_cnt_nxt_s;
  logic               busy_r;
  logic               xfer_s;
  logic               tx_valid_s;
  logic [7:0]         tx_data_s;
  logic [NUM_REQ-1:0] req_ready_s;

  // Round-robin search: first valid requester at or above rr_ptr_r, wrapping
  always_comb begin
    logic [CND_W-1:0] cand;
    logic             hit;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand        = '0;
    hit         = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand        = {1'b0, rr_ptr_r} + CND_W'(k);
      cand        = (cand >= CND_W'(NUM_REQ)) ? (cand - CND_W'(NUM_REQ)) : cand;
      hit         = req_valid[cand[IDX_W-1:0]] & ~win_found_s;
      win_idx_s   = hit ? cand[IDX_W-1:0] : win_idx_s;
      win_found_s = win_found_s | hit;
    end
  end

  assign xfer_s = req_valid[gidx_r] & tx_ready;

  // Next-state logic and zero-latency pass-through of the granted stream
  always_comb begin
    state_nxt_s   = state_r;
    gidx_nxt_s    = gidx_r;
    grant_nxt_s   = grant_r;
    rr_ptr_nxt_s  = rr_ptr_r;
    gap_cnt_nxt_s = gap_cnt_r;
    tx_valid_s    = 1'b0;
    tx_data_s     = 8'd0;
    req_ready_s   = '0;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          state_nxt_s            = ST_SEND;
          gidx_nxt_s             = win_idx_s;
          grant_nxt_s            = '0;
          grant_nxt_s[win_idx_s] = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        tx_valid_s          = req_valid[gidx_r];
        tx_data_s           = req_valid[gidx_r] ? req_data[{gidx_r, 3'b000} +: 8] : 8'd0;
        req_ready_s[gidx_r] = tx_ready;
        // Grant is only released on the transfer of a last-flagged byte
        if (xfer_s && req_last[gidx_r]) begin
          grant_nxt_s  = '0;
          rr_ptr_nxt_s = (gidx_r == LAST_IDX) ? '0 : (gidx_r + IDX_W'(1));
          if (GAP_CYCLES > 0) begin
            state_nxt_s   = ST_GAP;
            gap_cnt_nxt_s = GAP_LOAD;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == 16'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          gap_cnt_nxt_s = gap_cnt_r - 16'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        grant_nxt_s = '0;
      end
    endcase
  end

  // State, owner, pointer, gap counter and busy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      gidx_r    <= '0;
      grant_r   <= '0;
      rr_ptr_r  <= '0;
      gap_cnt_r <= 16'd0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      gidx_r    <= gidx_nxt_s;
      grant_r   <= grant_nxt_s;
      rr_ptr_r  <= rr_ptr_nxt_s;
      gap_cnt_r <= gap_cnt_nxt_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
    end
  end

  // Gating with rst keeps uart_tx quiet the instant reset asserts
  assign tx_valid  = tx_valid_s & ~rst;
  assign tx_data   = rst ? 8'd0 : tx_data_s;
  assign req_ready = rst ? '0 : req_ready_s;
  assign grant     = grant_r;
  assign busy      = busy_r;

endmodule
